ram_bus_arbiter: RTL and testbench

//  Shares the single RAM port between the CPU micro-op datapath (MAR/RAM accesses)
//  and the program loader/debug port. Each requester runs a REQ/DONE handshake.
//  The arbiter grants one requester at a time and drives RAM address, data and control.
//  It inserts the configured RAM wait states, returns read data per requester,
//  and alternates round-robin under contention.

---
 rtl/ram_bus_arbiter_if.sv | 47 ++++
 rtl/ram_bus_arbiter.sv | 108 ++++++++++
 tb/tb_ram_bus_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_bus_arbiter_if.sv
// ram_bus_arbiter_if: CPU and loader request ports plus the shared RAM port.
// slave is the arbiter side; master is the requester/RAM side.
interface ram_bus_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              CPU_REQ;
  logic              CPU_WE;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic [DATA_W-1:0] CPU_WDATA;
  logic              CPU_GNT;
  logic              CPU_DONE;
  logic [DATA_W-1:0] CPU_RDATA;
  logic              LDR_REQ;
  logic              LDR_WE;
  logic [ADDR_W-1:0] LDR_ADDR;
  logic [DATA_W-1:0] LDR_WDATA;
  logic              LDR_GNT;
  logic              LDR_DONE;
  logic [DATA_W-1:0] LDR_RDATA;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] RAM_WDATA;
  logic [DATA_W-1:0] RAM_RDATA;
  logic              RAM_RW;
  logic              RAM_EN;
  logic              BUSY;

  modport slave (
    input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    input  LDR_REQ, LDR_WE, LDR_ADDR, LDR_WDATA,
    input  RAM_RDATA,
    output CPU_GNT, CPU_DONE, CPU_RDATA,
    output LDR_GNT, LDR_DONE, LDR_RDATA,
    output RAM_ADDR, RAM_WDATA, RAM_RW, RAM_EN,
    output BUSY
  );

  modport master (
    output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    output LDR_REQ, LDR_WE, LDR_ADDR, LDR_WDATA,
    output RAM_RDATA,
    input  CPU_GNT, CPU_DONE, CPU_RDATA,
    input  LDR_GNT, LDR_DONE, LDR_RDATA,
    input  RAM_ADDR, RAM_WDATA, RAM_RW, RAM_EN,
    input  BUSY
  );
endinterface

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: round-robin sharing of one RAM port between the CPU
// datapath and the loader, with configurable RAM wait states.
module ram_bus_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic CLK,
  input  logic RST,
  ram_bus_arbiter_if.slave bus
);

  localparam int WCW =
    (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [WCW-1:0] WS_INIT = WCW'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WCW-1:0]    wait_q;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rd_q;
  logic [DATA_W-1:0] ldr_rd_q;
  logic              grant;
  logic              pick;
  logic              busy;

  // owner_q doubles as last_owner: 0 = CPU, 1 = loader
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    pick    = owner_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          (bus.CPU_REQ && bus.LDR_REQ): begin
            grant = 1'b1;
            pick  = ~owner_q;
          end
          (bus.CPU_REQ && !bus.LDR_REQ): begin
            grant = 1'b1;
            pick  = 1'b0;
          end
          (!bus.CPU_REQ && bus.LDR_REQ): begin
            grant = 1'b1;
            pick  = 1'b1;
          end
          default: ;
        endcase
        if (grant) state_d = ACCESS;
      end
      ACCESS: if (wait_q == '0) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      owner_q  <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cpu_rd_q <= '0;
      ldr_rd_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= pick;
        we_q    <= pick ? bus.LDR_WE : bus.CPU_WE;
        addr_q  <= pick ? bus.LDR_ADDR : bus.CPU_ADDR;
        wdata_q <= pick ? bus.LDR_WDATA : bus.CPU_WDATA;
        wait_q  <= WS_INIT;
      end else if (state_q == ACCESS) begin
        if (wait_q != '0) begin
          wait_q <= wait_q - 1'b1;
        end else if (!we_q) begin
          if (owner_q) ldr_rd_q <= bus.RAM_RDATA;
          else         cpu_rd_q <= bus.RAM_RDATA;
        end
      end
    end
  end

  assign busy          = (state_q != IDLE);
  assign bus.BUSY      = busy;
  assign bus.CPU_GNT   = busy && !owner_q;
  assign bus.LDR_GNT   = busy && owner_q;
  assign bus.CPU_DONE  = (state_q == DONE) && !owner_q;
  assign bus.LDR_DONE  = (state_q == DONE) && owner_q;
  assign bus.CPU_RDATA = cpu_rd_q;
  assign bus.LDR_RDATA = ldr_rd_q;
  assign bus.RAM_EN    = (state_q == ACCESS);
  assign bus.RAM_RW    = (state_q == ACCESS) && we_q;
  assign bus.RAM_ADDR  = addr_q;
  assign bus.RAM_WDATA = wdata_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: random CPU/loader traffic against a RAM model,
// checked by a scoreboard monitor and a queue/array reference model.
module tb_ram_bus_arbiter;

  localparam int WS = 1;

  typedef struct packed {
    logic       r;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } txn_t;

  logic CLK;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  logic       req   [2];
  logic       we    [2];
  logic [7:0] addr  [2];
  logic [7:0] wdata [2];

  logic       l2_req;
  logic       l2_we;
  logic [7:0] l2_addr;

  txn_t pend[$];
  int   order_q[$];

  ram_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  ram_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus2 ();

  ram_bus_arbiter #(
    .ADDR_W(8), .DATA_W(8), .WAIT_STATES(WS)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  ram_bus_arbiter #(
    .ADDR_W(8), .DATA_W(8), .WAIT_STATES(0)
  ) dut0 (
    .CLK(CLK), .RST(RST), .bus(bus2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign bus.CPU_REQ   = req[0];
  assign bus.CPU_WE    = we[0];
  assign bus.CPU_ADDR  = addr[0];
  assign bus.CPU_WDATA = wdata[0];
  assign bus.LDR_REQ   = req[1];
  assign bus.LDR_WE    = we[1];
  assign bus.LDR_ADDR  = addr[1];
  assign bus.LDR_WDATA = wdata[1];

  assign bus2.CPU_REQ   = 1'b0;
  assign bus2.CPU_WE    = 1'b0;
  assign bus2.CPU_ADDR  = 8'h00;
  assign bus2.CPU_WDATA = 8'h00;
  assign bus2.LDR_REQ   = l2_req;
  assign bus2.LDR_WE    = l2_we;
  assign bus2.LDR_ADDR  = l2_addr;
  assign bus2.LDR_WDATA = 8'h00;
  assign bus2.RAM_RDATA = bus2.RAM_ADDR ^ 8'h5A;

  logic [1:0] g;
  logic [1:0] dn;
  logic [7:0] rdv [2];
  logic [38:0] all_out;
  logic [38:0] all_out2;
  assign g  = {bus.LDR_GNT, bus.CPU_GNT};
  assign dn = {bus.LDR_DONE, bus.CPU_DONE};
  assign rdv[0] = bus.CPU_RDATA;
  assign rdv[1] = bus.LDR_RDATA;
  assign all_out = {
    bus.CPU_GNT, bus.CPU_DONE, bus.CPU_RDATA,
    bus.LDR_GNT, bus.LDR_DONE, bus.LDR_RDATA,
    bus.RAM_ADDR, bus.RAM_WDATA,
    bus.RAM_RW, bus.RAM_EN, bus.BUSY};
  assign all_out2 = {
    bus2.CPU_GNT, bus2.CPU_DONE, bus2.CPU_RDATA,
    bus2.LDR_GNT, bus2.LDR_DONE, bus2.LDR_RDATA,
    bus2.RAM_ADDR, bus2.RAM_WDATA,
    bus2.RAM_RW, bus2.RAM_EN, bus2.BUSY};

  function automatic logic [7:0] init_val(input int i);
    if (i == 'h10) return 8'hA5;
    return 8'((i * 37 + 11) & 'hFF);
  endfunction

  logic [7:0] mem [256];
  bit mem_ok = 0;
  assign bus.RAM_RDATA = mem[bus.RAM_ADDR];
  always @(posedge CLK) begin
    if (!mem_ok) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_ok <= 1'b1;
    end else if (bus.RAM_EN && bus.RAM_RW) begin
      mem[bus.RAM_ADDR] <= bus.RAM_WDATA;
    end
  end

  logic [1:0] req_s;
  always @(posedge CLK) req_s <= {req[1], req[0]};

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // scoreboard monitor: reference memory, per-requester read data
  // and the round-robin rule
  initial begin
    int         cur_r;
    txn_t       cur;
    int         gl, el, dc, idx, r, exp_o, prev_owner;
    bit         prev_busy;
    logic [7:0] exp_rd [2];
    logic [7:0] ref_mem [256];
    bit         ref_ok;
    ref_ok = 0;
    cur_r = -1;
    cur = '0;
    gl = 0; el = 0; dc = 0;
    prev_owner = 1;
    prev_busy = 0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    forever begin
      @(negedge CLK);
      if (!ref_ok) begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        ref_ok = 1;
      end
      if (!mon_en) begin
        cur_r = -1;
        prev_owner = 1;
        prev_busy = 0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        pend.delete();
        order_q.delete();
      end else begin
        chk("gnt_onehot", 64'(g == 2'b11), 0);
        chk("busy", 64'(bus.BUSY), 64'(g != 2'b00));
        chk("rw_outside_en",
            64'(bus.RAM_RW && !bus.RAM_EN), 0);
        chk("done_wo_gnt", 64'(dn & ~g), 0);
        if (g != 2'b00 && cur_r < 0) begin
          r = g[1] ? 1 : 0;
          if (req_s == 2'b11) exp_o = 1 - prev_owner;
          else exp_o = req_s[1] ? 1 : 0;
          chk("grant_owner", 64'(r), 64'(exp_o));
          chk("turnaround_busy", 64'(prev_busy), 0);
          idx = -1;
          for (int i = 0; i < pend.size(); i++)
            if (idx < 0 && pend[i].r == 1'(r)) idx = i;
          chk("spurious_grant", 64'(idx < 0), 0);
          if (idx >= 0) begin
            cur = pend[idx];
            pend.delete(idx);
          end else begin
            cur = '0;
          end
          order_q.push_back(r);
          prev_owner = r;
          cur_r = r;
          gl = 0; el = 0; dc = 0;
        end
        if (cur_r >= 0) begin
          if (g != 2'b00) begin
            gl++;
            chk("gnt_owner", 64'(g[cur_r]), 1);
            if (bus.RAM_EN) begin
              el++;
              chk("ram_addr", 64'(bus.RAM_ADDR), 64'(cur.addr));
              chk("ram_rw", 64'(bus.RAM_RW), 64'(cur.we));
              if (cur.we)
                chk("ram_wdata", 64'(bus.RAM_WDATA),
                    64'(cur.wdata));
            end
            if (dn[cur_r]) begin
              dc++;
              chk("done_gnt_len", 64'(gl), 64'(WS + 2));
              chk("done_en_len", 64'(el), 64'(WS + 1));
              if (cur.we) ref_mem[cur.addr] = cur.wdata;
              else exp_rd[cur_r] = ref_mem[cur.addr];
            end
          end else begin
            chk("done_once", 64'(dc), 1);
            chk("gnt_len", 64'(gl), 64'(WS + 2));
            cur_r = -1;
          end
        end
        chk("cpu_rdata", 64'(rdv[0]), 64'(exp_rd[0]));
        chk("ldr_rdata", 64'(rdv[1]), 64'(exp_rd[1]));
        prev_busy = bus.BUSY;
      end
    end
  end

  task automatic xfer(input int r, input txn_t t, input bit drop,
                      input bit keep, input bit lat);
    int w;
    t.r = 1'(r);
    we[r] = t.we;
    addr[r] = t.addr;
    wdata[r] = t.wdata;
    req[r] = 1'b1;
    pend.push_back(t);
    w = 0;
    do begin @(negedge CLK); w++; end while (!g[r] && w < 200);
    chk("gnt_timeout", 64'(g[r]), 1);
    if (lat) chk("req_to_gnt", 64'(w), 1);
    if (drop) req[r] = 1'b0;
    w = 0;
    do begin @(negedge CLK); w++; end while (!dn[r] && w < 200);
    chk("done_timeout", 64'(dn[r]), 1);
    if (!keep) req[r] = 1'b0;
  endtask

  task automatic drive(input int r, input int n, input bit hold);
    txn_t t;
    bit   keep;
    for (int k = 0; k < n; k++) begin
      if (!req[r] && !hold)
        repeat ($urandom_range(0, 3)) @(negedge CLK);
      t.r = 1'(r);
      t.we = 1'($urandom_range(0, 1));
      t.addr = 8'($urandom_range(0, 15));
      t.wdata = 8'($urandom);
      keep = (k != n - 1) && (hold || $urandom_range(0, 1) == 1);
      xfer(r, t, !hold && $urandom_range(0, 3) == 0, keep, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    txn_t t;
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0;
      addr[i] = 8'h00; wdata[i] = 8'h00;
    end
    l2_req = 1'b0; l2_we = 1'b0; l2_addr = 8'h00;
    #1;
    chk("reset_outputs", 64'(all_out), 0);
    chk("reset_outputs_ws0", 64'(all_out2), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    mon_en = 1'b1;
    @(negedge CLK);

    t = '{r: 1'b0, we: 1'b0, addr: 8'h10, wdata: 8'h00};
    xfer(0, t, 1'b0, 1'b0, 1'b1);
    chk("t1_cpu_rdata", 64'(bus.CPU_RDATA), 64'hA5);
    @(negedge CLK);

    t = '{r: 1'b1, we: 1'b1, addr: 8'h20, wdata: 8'h3C};
    xfer(1, t, 1'b0, 1'b0, 1'b1);
    chk("t3_cpu_rdata_kept", 64'(bus.CPU_RDATA), 64'hA5);
    chk("t3_ldr_rdata_kept", 64'(bus.LDR_RDATA), 64'h00);
    @(negedge CLK);
    t = '{r: 1'b0, we: 1'b0, addr: 8'h20, wdata: 8'h00};
    xfer(0, t, 1'b0, 1'b0, 1'b1);
    chk("t3_readback", 64'(bus.CPU_RDATA), 64'h3C);
    @(negedge CLK);

    t = '{r: 1'b0, we: 1'b0, addr: 8'h11, wdata: 8'h00};
    xfer(0, t, 1'b1, 1'b0, 1'b1);
    repeat (5) @(negedge CLK);
    chk("t4_no_regrant", 64'(g), 0);

    fork
      drive(0, 30, 1'b0);
      drive(1, 30, 1'b0);
    join
    repeat (4) @(negedge CLK);

    t = '{r: 1'b0, we: 1'b0, addr: 8'h30, wdata: 8'h00};
    we[0] = 1'b0; addr[0] = 8'h30; req[0] = 1'b1;
    pend.push_back(t);
    @(negedge CLK);
    chk("t5_in_access", 64'(bus.RAM_EN), 1);
    #2;
    mon_en = 1'b0;
    RST = 1'b0;
    #1;
    chk("t5_rst_outputs", 64'(all_out), 0);
    req[0] = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      chk("t5_rst_hold", 64'(all_out), 0);
    end
    RST = 1'b1;
    mon_en = 1'b1;
    fork
      drive(0, 4, 1'b1);
      drive(1, 4, 1'b1);
    join
    repeat (3) @(negedge CLK);
    chk("t2_grant_count", 64'(order_q.size()), 8);
    for (int i = 0; i < 8; i++)
      if (i < order_q.size())
        chk("t2_grant_order", 64'(order_q[i]), 64'(i % 2));

    @(negedge CLK);
    l2_we = 1'b0; l2_addr = 8'h05; l2_req = 1'b1;
    @(negedge CLK);
    chk("t6_gnt_c1", 64'(bus2.LDR_GNT), 1);
    chk("t6_en_c1", 64'(bus2.RAM_EN), 1);
    chk("t6_done_c1", 64'(bus2.LDR_DONE), 0);
    l2_req = 1'b0;
    @(negedge CLK);
    chk("t6_gnt_c2", 64'(bus2.LDR_GNT), 1);
    chk("t6_en_c2", 64'(bus2.RAM_EN), 0);
    chk("t6_done_c2", 64'(bus2.LDR_DONE), 1);
    chk("t6_ldr_rdata", 64'(bus2.LDR_RDATA), 64'h5F);
    chk("t6_cpu_rdata", 64'(bus2.CPU_RDATA), 0);
    @(negedge CLK);
    chk("t6_gnt_c3", 64'(bus2.LDR_GNT), 0);
    chk("t6_busy_c3", 64'(bus2.BUSY), 0);
    chk("t6_done_c3", 64'(bus2.LDR_DONE), 0);

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
